// File: rtl/mouse_cmd_scheduler.sv
// Host-to-mouse command sequencer: sends an opcode and optional argument byte, checks each ACK,
// retries on resend/timeout and reports completion or failure.
module mouse_cmd_scheduler #(
   parameter int unsigned TIMEOUT_CYCLES = 2500000,
   parameter int unsigned MAX_RETRY      = 3,
   parameter int unsigned CNT_W          = 24
) (
   input  logic       clk,
   input  logic       reset,            // asynchronous, active low
   input  logic       cmd_req,
   input  logic [7:0] cmd_code,
   input  logic [7:0] cmd_arg,
   input  logic       cmd_has_arg,
   output logic       cmd_busy,
   output logic       cmd_done,
   output logic       cmd_err,
   output logic [1:0] err_code,
   output logic       stream_pause,
   output logic       send_byte,
   output logic [7:0] byte_to_send,
   input  logic       byte_sent,
   output logic       read_enable,
   input  logic [7:0] byte_read,
   input  logic [1:0] byte_error_code,
   input  logic       byte_ready,
   output logic [3:0] curr_state
);

   typedef enum logic [3:0] {
      StIdle        = 4'd0,
      StSendOp      = 4'd1,
      StWaitSentOp  = 4'd2,
      StWaitAckOp   = 4'd3,
      StSendArg     = 4'd4,
      StWaitSentArg = 4'd5,
      StWaitAckArg  = 4'd6,
      StDone        = 4'd7,
      StFail        = 4'd8
   } state_e;

   localparam logic [CNT_W-1:0] TimeoutMax = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [2:0]       RetryMax   = 3'(MAX_RETRY);

   state_e           state_q, state_d;
   logic [7:0]       code_q, code_d;
   logic [7:0]       arg_q, arg_d;
   logic             has_arg_q, has_arg_d;
   logic [2:0]       retry_q, retry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       err_code_q, err_code_d;
   logic [7:0]       byte_to_send_q, byte_to_send_d;
   logic             send_byte_q, send_byte_d;
   logic             cmd_done_q, cmd_done_d;
   logic             cmd_err_q, cmd_err_d;
   logic             busy_q, busy_d;
   logic             read_en_q, read_en_d;
   logic             resend;
   logic [1:0]       exhaust_code;
   logic             ack_op;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= StIdle;
         code_q         <= 8'h00;
         arg_q          <= 8'h00;
         has_arg_q      <= 1'b0;
         retry_q        <= 3'd0;
         cnt_q          <= '0;
         err_code_q     <= 2'b00;
         byte_to_send_q <= 8'h00;
         send_byte_q    <= 1'b0;
         cmd_done_q     <= 1'b0;
         cmd_err_q      <= 1'b0;
         busy_q         <= 1'b0;
         read_en_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         code_q         <= code_d;
         arg_q          <= arg_d;
         has_arg_q      <= has_arg_d;
         retry_q        <= retry_d;
         cnt_q          <= cnt_d;
         err_code_q     <= err_code_d;
         byte_to_send_q <= byte_to_send_d;
         send_byte_q    <= send_byte_d;
         cmd_done_q     <= cmd_done_d;
         cmd_err_q      <= cmd_err_d;
         busy_q         <= busy_d;
         read_en_q      <= read_en_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      code_d         = code_q;
      arg_d          = arg_q;
      has_arg_d      = has_arg_q;
      retry_d        = retry_q;
      cnt_d          = cnt_q;
      err_code_d     = err_code_q;
      byte_to_send_d = byte_to_send_q;
      send_byte_d    = 1'b0;
      cmd_done_d     = 1'b0;
      cmd_err_d      = 1'b0;
      resend         = 1'b0;
      exhaust_code   = 2'b00;
      ack_op         = (state_q == StWaitAckOp);

      case (state_q)
         StIdle: begin
            if (cmd_req) begin
               code_d     = cmd_code;
               arg_d      = cmd_arg;
               has_arg_d  = cmd_has_arg;
               err_code_d = 2'b00;
               retry_d    = 3'd0;
               state_d    = StSendOp;
            end
         end
         StSendOp: begin
            send_byte_d    = 1'b1;
            byte_to_send_d = code_q;
            state_d        = StWaitSentOp;
         end
         StSendArg: begin
            send_byte_d    = 1'b1;
            byte_to_send_d = arg_q;
            state_d        = StWaitSentArg;
         end
         StWaitSentOp, StWaitSentArg: begin
            if (byte_sent) begin
               cnt_d   = '0;
               state_d = (state_q == StWaitSentOp) ? StWaitAckOp : StWaitAckArg;
            end
         end
         StWaitAckOp, StWaitAckArg: begin
            cnt_d = cnt_q + CNT_W'(1);
            // A reply landing on the expiry cycle takes precedence over the timeout.
            if (byte_ready) begin
               if (byte_error_code != 2'b00 || byte_read == 8'hFE) begin
                  resend       = 1'b1;
                  exhaust_code = 2'b10;
               end else if (byte_read == 8'hFA) begin
                  retry_d = 3'd0;
                  state_d = (ack_op && has_arg_q) ? StSendArg : StDone;
               end else begin
                  err_code_d = 2'b11;
                  state_d    = StFail;
               end
            end else if (cnt_q == TimeoutMax) begin
               resend       = 1'b1;
               exhaust_code = 2'b01;
            end
            if (resend) begin
               if (retry_q < RetryMax) begin
                  retry_d = retry_q + 3'd1;
                  state_d = ack_op ? StSendOp : StSendArg;
               end else begin
                  err_code_d = exhaust_code;
                  state_d    = StFail;
               end
            end
         end
         StDone: begin
            cmd_done_d = 1'b1;
            state_d    = StIdle;
         end
         StFail: begin
            cmd_err_d = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase

      busy_d    = (state_d != StIdle);
      read_en_d = (state_d == StWaitAckOp) || (state_d == StWaitAckArg);
   end

   assign cmd_busy     = busy_q;
   assign stream_pause = busy_q;
   assign cmd_done     = cmd_done_q;
   assign cmd_err      = cmd_err_q;
   assign err_code     = err_code_q;
   assign send_byte    = send_byte_q;
   assign byte_to_send = byte_to_send_q;
   assign read_enable  = read_en_q;
   assign curr_state   = state_q;

endmodule

// File: doc/mouse_cmd_scheduler.md
Name: mouse_cmd_scheduler

Overview:
Owns the PS/2 transmitter/receiver pair after mouse initialisation and runs host configuration commands such as set sample rate (F3 xx), set resolution (E8 xx) and disable/enable stream (F5/F4). Each command is an opcode with an optional argument byte. The block checks the mouse ACK after every byte, retries on resend/timeout and reports the outcome. While a command is in flight it asserts STREAM_PAUSE so the mouse master state machine holds its 3-byte packet decoding.

Parameters:
TIMEOUT_CYCLES, 2500000, max cycles from BYTE_SENT to BYTE_READY before a timeout (50 ms at 50 MHz)
MAX_RETRY, 3, resend attempts per byte before failing (1..7)
CNT_W, 24, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous active-low reset (low = reset)
CMD_REQ  in  1  request strobe, sampled only in IDLE
CMD_CODE  in  8  command opcode
CMD_ARG  in  8  argument byte
CMD_HAS_ARG  in  1  1 = send CMD_ARG after opcode ACK
CMD_BUSY  out  1  high from accept until DONE/FAIL exit
CMD_DONE  out  1  one-cycle pulse, command completed
CMD_ERR  out  1  one-cycle pulse, command failed
ERR_CODE  out  2  00 none, 01 timeout, 10 resend retries exhausted, 11 unexpected reply (FC or other); held until next accept
STREAM_PAUSE  out  1  equals CMD_BUSY
SEND_BYTE  out  1  one-cycle pulse to transmitter
BYTE_TO_SEND  out  8  byte for transmitter, held stable
BYTE_SENT  in  1  transmitter finished pulse
READ_ENABLE  out  1  receiver enable
BYTE_READ  in  8  received byte
BYTE_ERROR_CODE  in  2  receiver error, 00 = good
BYTE_READY  in  1  receiver byte-valid pulse
CURR_STATE  out  4  state encoding for debug

Behaviour:
- Reset (async, RESET low): state IDLE; all outputs 0 (BYTE_TO_SEND 00, ERR_CODE 00); retry and timeout counters 0. Reset mid-command abandons it without DONE/ERR; SEND_BYTE is forced low immediately.
- All outputs are registered. States: IDLE 0, SEND_OP 1, WAIT_SENT_OP 2, WAIT_ACK_OP 3, SEND_ARG 4, WAIT_SENT_ARG 5, WAIT_ACK_ARG 6, DONE 7, FAIL 8. Unused encodings go to IDLE.
- IDLE: if CMD_REQ=1, latch CMD_CODE/CMD_ARG/CMD_HAS_ARG, clear ERR_CODE and retry count, go to SEND_OP. CMD_BUSY rises the next cycle. CMD_REQ outside IDLE is ignored.
- SEND_x: BYTE_TO_SEND = latched byte; SEND_BYTE pulses 1 cycle; go to WAIT_SENT_x.
- WAIT_SENT_x: wait for BYTE_SENT (no timeout). Clear the timeout counter, then go to WAIT_ACK_x.
- WAIT_ACK_x: READ_ENABLE=1; the counter increments each cycle. On BYTE_READY, evaluate in priority order:
  - BYTE_ERROR_CODE!=00 or BYTE_READ=FE: this is a resend case.
  - BYTE_READ=FA with good code: from OP go to SEND_ARG if HAS_ARG, else DONE; from ARG go to DONE.
  - Any other byte (including FC): go to FAIL with ERR_CODE=11.
- Resend case: if retry<MAX_RETRY, increment retry and return to SEND_x (same byte). Otherwise go to FAIL with ERR_CODE=10.
- Timeout: counter reaches TIMEOUT_CYCLES with no BYTE_READY. Treated as resend, but on exhaustion ERR_CODE=01. If BYTE_READY arrives in the same cycle as expiry, BYTE_READY wins.
- The retry count resets to 0 on each successful FA, so the budget is per byte.
- DONE: CMD_DONE pulses 1 cycle, then IDLE. FAIL: CMD_ERR pulses 1 cycle, then IDLE. CMD_BUSY/STREAM_PAUSE drop on entry to IDLE.
- Latency with zero-delay peers: request to first SEND_BYTE is 2 cycles; final FA BYTE_READY to CMD_DONE is 2 cycles.
- A BYTE_READY seen in WAIT_SENT_x is ignored.

Test Plan:
- No-arg command: CMD_CODE=F5, HAS_ARG=0, mouse replies FA → exactly one SEND_BYTE with F5; CMD_DONE pulse; ERR_CODE=00; BUSY high throughout.
- Arg command: F3 then 28, both ACK FA → SEND_BYTE sequence F3, 28; single CMD_DONE; STREAM_PAUSE low after.
- Resend: reply FE twice then FA to E8 → E8 sent 3 times; DONE. Four consecutive FE (MAX_RETRY=3) → CMD_ERR with ERR_CODE=10 after the 4th send.
- Timeout (TIMEOUT_CYCLES=100): no reply → 4 sends spaced ≥100 cycles; CMD_ERR with ERR_CODE=01. BYTE_READY=FA on the expiry cycle → DONE, no resend.
- Bad reply: FC to the opcode → CMD_ERR with ERR_CODE=11, argument never sent. Parity error code 01 with FA → treated as resend.
- Async reset pulled low in WAIT_ACK_ARG → all outputs 0 with no clock edge; after release, IDLE, no DONE/ERR; a new CMD_REQ is accepted normally.
